// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: load extraction modes and register index helpers.
package wb_pkg;

   typedef enum logic [2:0] {
      LT_PASS = 3'd0,
      LT_LB   = 3'd1,
      LT_LBU  = 3'd2,
      LT_LH   = 3'd3,
      LT_LHU  = 3'd4,
      LT_LW   = 3'd5
   } load_type_e;

   typedef logic [4:0] reg_idx_t;

   function automatic logic [31:0] rd_onehot(input reg_idx_t rd);
      rd_onehot = 32'd1 << rd;
   endfunction

endpackage

// File: rtl/wb_ll_fifo.sv
// Circular buffer holding long-latency results until the register-file port is free.
module wb_ll_fifo
   import wb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  reg_idx_t          push_rd,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output reg_idx_t          head_rd,
   output logic [DATA_W-1:0] head_data,
   output logic              empty,
   output logic              full,
   output logic [31:0]       pending_mask
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   // Entry type lives here because its data width follows DATA_W.
   typedef struct packed {
      reg_idx_t          rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   wb_entry_t        mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   // NOTE: the payload array has no reset; the valid bits alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{rd: push_rd, data: push_data};
   end

   // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld    <= '0;
      end else begin
         if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            vld[rd_ptr] <= 1'b0;
         end
         if (push) begin
            wr_ptr      <= wr_ptr + 1'b1;
            vld[wr_ptr] <= 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign head_rd   = mem[rd_ptr].rd;
   assign head_data = mem[rd_ptr].data;

   // NOTE: defaults are assigned first so no path through the block infers a latch.
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld[i]) pending_mask = pending_mask | rd_onehot(mem[i].rd);
      end
   end

endmodule

// File: rtl/wb_stage_arb.sv
// MIPS writeback stage: MEM/WB register, sub-word load extraction, and arbitration of the
// single register-file write port between the pipeline and queued long-latency results.
module wb_stage_arb
   import wb_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int LL_DEPTH     = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_wb_valid,
   input  logic              mem_wb_reg_write,
   input  logic [4:0]        mem_wb_rd,
   input  logic [DATA_W-1:0] mem_wb_data,
   input  logic [2:0]        mem_wb_load_type,
   input  logic [1:0]        mem_wb_low_two_bits,
   input  logic              ll_valid,
   output logic              ll_ready,
   input  logic [4:0]        ll_rd,
   input  logic [DATA_W-1:0] ll_data,
   output logic [31:0]       ll_pending_mask,
   output logic              wb_stall_req,
   output logic              final_reg_write,
   output logic [4:0]        final_dst_reg_write,
   output logic [DATA_W-1:0] final_data_reg_write
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic              s_valid;
   logic              s_reg_write;
   reg_idx_t          s_rd;
   logic [DATA_W-1:0] s_data;
   logic [2:0]        s_load_type;
   logic [1:0]        s_low;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_valid     <= 1'b0;
         s_reg_write <= 1'b0;
         s_rd        <= '0;
         s_data      <= '0;
         s_load_type <= '0;
         s_low       <= '0;
      end else begin
         s_valid     <= mem_wb_valid;
         s_reg_write <= mem_wb_reg_write;
         s_rd        <= mem_wb_rd;
         s_data      <= mem_wb_data;
         s_load_type <= mem_wb_load_type;
         s_low       <= mem_wb_low_two_bits;
      end
   end

   // Halves use only low[1]; unused encodings fall through to PASS.
   function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] data,
                                                 input logic [2:0] lt, input logic [1:0] low);
      logic [7:0]  b;
      logic [15:0] h;
      b = data[{low, 3'b000} +: 8];
      h = low[1] ? data[31:16] : data[15:0];
      case (load_type_e'(lt))
         LT_LB:   extract = {{(DATA_W - 8){b[7]}}, b};
         LT_LBU:  extract = {{(DATA_W - 8){1'b0}}, b};
         LT_LH:   extract = {{(DATA_W - 16){h[15]}}, h};
         LT_LHU:  extract = {{(DATA_W - 16){1'b0}}, h};
         default: extract = data;
      endcase
   endfunction

   logic              pipe_wr;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_empty;
   logic              fifo_full;
   reg_idx_t          head_rd;
   logic [DATA_W-1:0] head_data;

   assign pipe_wr   = s_valid & s_reg_write & (s_rd != '0);
   assign fifo_pop  = ~pipe_wr & ~fifo_empty;
   assign ll_ready  = ~fifo_full;
   // Results aimed at $0 complete the handshake but are never stored.
   assign fifo_push = ll_valid & ll_ready & (ll_rd != '0);

   wb_ll_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (LL_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push         (fifo_push),
      .push_rd      (ll_rd),
      .push_data    (ll_data),
      .pop          (fifo_pop),
      .head_rd      (head_rd),
      .head_data    (head_data),
      .empty        (fifo_empty),
      .full         (fifo_full),
      .pending_mask (ll_pending_mask)
   );

   always_comb begin
      final_reg_write      = 1'b0;
      final_dst_reg_write  = '0;
      final_data_reg_write = '0;
      if (pipe_wr) begin
         final_reg_write      = 1'b1;
         final_dst_reg_write  = s_rd;
         final_data_reg_write = extract(s_data, s_load_type, s_low);
      end else if (!fifo_empty) begin
         final_reg_write      = 1'b1;
         final_dst_reg_write  = head_rd;
         final_data_reg_write = head_data;
      end
   end

   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_nxt;

   always_comb begin
      starve_nxt = starve_cnt;
      if (fifo_empty || fifo_pop) starve_nxt = '0;
      else if (starve_cnt != LIMIT) starve_nxt = starve_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt   <= '0;
         wb_stall_req <= 1'b0;
      end else begin
         starve_cnt   <= starve_nxt;
         wb_stall_req <= (starve_nxt == LIMIT);
      end
   end

endmodule

// File: tb/tb_wb_stage_arb.sv
// Scoreboard bench for wb_stage_arb: expected writes are queued as stimulus is driven and
// retired against the register-file port every cycle.
module tb_wb_stage_arb;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mem_wb_valid, mem_wb_reg_write;
   logic [4:0]  mem_wb_rd;
   logic [31:0] mem_wb_data;
   logic [2:0]  mem_wb_load_type;
   logic [1:0]  mem_wb_low_two_bits;
   logic        ll_valid, ll_ready;
   logic [4:0]  ll_rd;
   logic [31:0] ll_data;
   logic [31:0] ll_pending_mask;
   logic        wb_stall_req, final_reg_write;
   logic [4:0]  final_dst_reg_write;
   logic [31:0] final_data_reg_write;

   always #5 clk = ~clk;

   wb_stage_arb #(.DATA_W(32), .LL_DEPTH(4), .STARVE_LIMIT(3)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .mem_wb_valid         (mem_wb_valid),
      .mem_wb_reg_write     (mem_wb_reg_write),
      .mem_wb_rd            (mem_wb_rd),
      .mem_wb_data          (mem_wb_data),
      .mem_wb_load_type     (mem_wb_load_type),
      .mem_wb_low_two_bits  (mem_wb_low_two_bits),
      .ll_valid             (ll_valid),
      .ll_ready             (ll_ready),
      .ll_rd                (ll_rd),
      .ll_data              (ll_data),
      .ll_pending_mask      (ll_pending_mask),
      .wb_stall_req         (wb_stall_req),
      .final_reg_write      (final_reg_write),
      .final_dst_reg_write  (final_dst_reg_write),
      .final_data_reg_write (final_data_reg_write)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   int          total = 0;
   int          bad = 0;
   ent_t        llq[$];
   logic        m_pvld = 1'b0;
   logic [4:0]  m_prd = '0;
   logic [31:0] m_pdata = '0;
   logic [31:0] stim_exp = '0;
   int          m_starve = 0;
   logic        m_stall = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      mem_wb_valid        = 1'b0;
      mem_wb_reg_write    = 1'b0;
      mem_wb_rd           = '0;
      mem_wb_data         = '0;
      mem_wb_load_type    = '0;
      mem_wb_low_two_bits = '0;
      ll_valid            = 1'b0;
      ll_rd               = '0;
      ll_data             = '0;
      stim_exp            = '0;
   endtask

   task automatic drive_pipe(input logic [4:0] rd, input logic [31:0] data, input logic [2:0] lt,
                             input logic [1:0] low, input logic [31:0] exp);
      mem_wb_valid        = 1'b1;
      mem_wb_reg_write    = 1'b1;
      mem_wb_rd           = rd;
      mem_wb_data         = data;
      mem_wb_load_type    = lt;
      mem_wb_low_two_bits = low;
      stim_exp            = exp;
   endtask

   task automatic drive_ll(input logic [4:0] rd, input logic [31:0] data);
      ll_valid = 1'b1;
      ll_rd    = rd;
      ll_data  = data;
   endtask

   // One clock: compare the port against the model mid-cycle, then advance the model.
   task automatic cycle();
      logic [31:0] mask;
      logic        pop, push;
      int          n_starve;
      if (m_stall) mem_wb_valid = 1'b0;
      @(negedge clk);
      mask = '0;
      foreach (llq[i]) mask |= 32'd1 << llq[i].rd;
      check("ll_ready", {31'd0, ll_ready}, {31'd0, llq.size() < 4});
      check("pending_mask", ll_pending_mask, mask);
      check("stall_req", {31'd0, wb_stall_req}, {31'd0, m_stall});
      if (m_pvld) begin
         check("pipe_we", {31'd0, final_reg_write}, 32'd1);
         check("pipe_rd", {27'd0, final_dst_reg_write}, {27'd0, m_prd});
         check("pipe_data", final_data_reg_write, m_pdata);
      end else if (llq.size() > 0) begin
         check("ll_we", {31'd0, final_reg_write}, 32'd1);
         check("ll_rd", {27'd0, final_dst_reg_write}, {27'd0, llq[0].rd});
         check("ll_data", final_data_reg_write, llq[0].data);
      end else begin
         check("idle_we", {31'd0, final_reg_write}, 32'd0);
         check("idle_rd", {27'd0, final_dst_reg_write}, 32'd0);
         check("idle_data", final_data_reg_write, 32'd0);
      end
      pop      = !m_pvld && (llq.size() > 0);
      push     = ll_valid && (llq.size() < 4) && (ll_rd != 5'd0);
      n_starve = (llq.size() == 0 || pop) ? 0 : ((m_starve < 3) ? m_starve + 1 : 3);
      @(posedge clk);
      #1;
      if (pop) void'(llq.pop_front());
      if (push) llq.push_back('{rd: ll_rd, data: ll_data});
      m_starve = n_starve;
      m_stall  = (n_starve == 3);
      m_pvld   = mem_wb_valid && mem_wb_reg_write && (mem_wb_rd != 5'd0);
      m_prd    = mem_wb_rd;
      m_pdata  = stim_exp;
      idle_inputs();
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      #2;
      check("rst_we", {31'd0, final_reg_write}, 32'd0);
      check("rst_rd", {27'd0, final_dst_reg_write}, 32'd0);
      check("rst_data", final_data_reg_write, 32'd0);
      check("rst_mask", ll_pending_mask, 32'd0);
      check("rst_ready", {31'd0, ll_ready}, 32'd1);
      check("rst_stall", {31'd0, wb_stall_req}, 32'd0);
      llq.delete();
      m_pvld   = 1'b0;
      m_prd    = '0;
      m_pdata  = '0;
      m_starve = 0;
      m_stall  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] LD = 32'h1234_80FF;

   initial begin
      idle_inputs();
      #3;
      do_reset();

      // Sub-word extraction; bytes of LD from low to high are FF 80 34 12.
      drive_pipe(5'd5,  LD, LT_LB,   2'b10, 32'h0000_0034); cycle();
      drive_pipe(5'd6,  LD, LT_LHU,  2'b11, 32'h0000_1234); cycle();
      drive_pipe(5'd7,  LD, LT_LB,   2'b01, 32'hFFFF_FF80); cycle();
      drive_pipe(5'd8,  LD, LT_LB,   2'b00, 32'hFFFF_FFFF); cycle();
      drive_pipe(5'd9,  LD, LT_LBU,  2'b01, 32'h0000_0080); cycle();
      drive_pipe(5'd10, LD, LT_LBU,  2'b11, 32'h0000_0012); cycle();
      drive_pipe(5'd11, LD, LT_LH,   2'b01, 32'hFFFF_80FF); cycle();
      drive_pipe(5'd12, LD, LT_LH,   2'b10, 32'h0000_1234); cycle();
      drive_pipe(5'd13, LD, LT_LHU,  2'b00, 32'h0000_80FF); cycle();
      drive_pipe(5'd14, LD, LT_LW,   2'b00, LD);            cycle();
      drive_pipe(5'd15, LD, LT_PASS, 2'b11, LD);            cycle();
      drive_pipe(5'd16, LD, 3'd6,    2'b01, LD);            cycle();
      drive_pipe(5'd17, LD, 3'd7,    2'b10, LD);            cycle();
      cycle();

      // Lone long-latency result with the pipeline idle.
      drive_ll(5'd9, 32'hDEAD_BEEF); cycle();
      repeat (2) cycle();

      // Pipeline saturates the port while the FIFO fills; starvation forces bubbles.
      for (int i = 0; i < 12; i++) begin
         if (i < 5) drive_ll(5'(10 + i), 32'hA000_0000 + 32'(i));
         if (i < 8) drive_pipe(5'(20 + i), 32'h5000_0000 + 32'(i), LT_PASS, 2'b00,
                               32'h5000_0000 + 32'(i));
         cycle();
      end
      repeat (6) cycle();

      // Pipeline write to $0 yields the port to the FIFO head; LL result to $0 is dropped.
      drive_ll(5'd7, 32'h7777_0007);
      drive_pipe(5'd3, 32'h0000_3333, LT_PASS, 2'b00, 32'h0000_3333); cycle();
      drive_pipe(5'd0, 32'h0000_BAD0, LT_PASS, 2'b00, 32'h0000_BAD0); cycle();
      repeat (2) cycle();
      drive_ll(5'd0, 32'hFFFF_FFFF); cycle();
      repeat (2) cycle();

      // Push and pop together at count 2.
      drive_ll(5'd1, 32'h0000_00A1);
      drive_pipe(5'd2, 32'h0000_0B02, LT_PASS, 2'b00, 32'h0000_0B02); cycle();
      drive_ll(5'd4, 32'h0000_00A4);
      drive_pipe(5'd3, 32'h0000_0B03, LT_PASS, 2'b00, 32'h0000_0B03); cycle();
      cycle();
      drive_ll(5'd8, 32'h0000_00A8); cycle();
      repeat (4) cycle();

      // Reset with three queued entries discards them.
      for (int i = 0; i < 3; i++) begin
         drive_ll(5'(11 + i), 32'hC000_0000 + 32'(i));
         drive_pipe(5'(17 + i), 32'h6000_0000 + 32'(i), LT_PASS, 2'b00, 32'h6000_0000 + 32'(i));
         cycle();
      end
      drive_pipe(5'd21, 32'h6000_0021, LT_PASS, 2'b00, 32'h6000_0021);
      do_reset();
      repeat (4) cycle();

      // Mixed random traffic.
      for (int i = 0; i < 60; i++) begin
         logic [31:0] d;
         d = $urandom;
         if ($urandom_range(0, 1) == 1) drive_ll(5'($urandom_range(0, 31)), $urandom);
         if ($urandom_range(0, 2) != 0) drive_pipe(5'($urandom_range(0, 31)), d, LT_PASS,
                                                   2'($urandom_range(0, 3)), d);
         cycle();
      end
      repeat (12) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
